// File: rtl/pipe_wb_arbiter.sv
// rtl/pipe_wb_arbiter.sv - register-file write-port arbiter between WB and the mul/div unit, with MD result FIFO and scoreboard
// Optional same-cycle MD bypass onto an idle port: define PIPE_WBARB_BYPASS_EN.
module pipe_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        WBwreg,
    input  logic [4:0]  WBwn,
    input  logic [31:0] WBdata,
    input  logic        MDissue,
    input  logic [4:0]  MDissue_wn,
    input  logic        MDvalid,
    input  logic [4:0]  MDwn,
    input  logic [31:0] MDdata,
    output logic        MDready,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    input  logic [4:0]  IDwn,
    input  logic        IDwreg,
    output logic        IDstall,
    output logic        RFwe,
    output logic [4:0]  RFwn,
    output logic [31:0] RFdata,
    output logic        MDoverflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    logic [4:0]    fifo_wn_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic          ovf_q;
    state_t        state_q;
    logic [DW-1:0] deny_q;

    logic wb_win, empty, full, head_grant, bypass, push;
    logic [4:0]  head_wn;
    logic [31:0] head_data;

    assign wb_win     = WBwreg && (WBwn != 5'd0);
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign head_grant = !wb_win && !empty;
    assign head_wn    = fifo_wn_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
`ifdef PIPE_WBARB_BYPASS_EN
    assign bypass     = MDvalid && empty && !wb_win && (MDwn != 5'd0);
`else
    assign bypass     = 1'b0;
`endif
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign MDready    = !full || head_grant;
    assign push       = MDvalid && MDready && (MDwn != 5'd0) && !bypass;
    assign count_d    = count_q + CW'(push) - CW'(head_grant);
    assign MDoverflow = ovf_q;

    always_comb begin
        RFwe   = 1'b0;
        RFwn   = 5'd0;
        RFdata = 32'd0;
        if (wb_win) begin
            RFwe   = 1'b1;
            RFwn   = WBwn;
            RFdata = WBdata;
        end else if (head_grant) begin
            RFwe   = 1'b1;
            RFwn   = head_wn;
            RFdata = head_data;
        end else if (bypass) begin
            RFwe   = 1'b1;
            RFwn   = MDwn;
            RFdata = MDdata;
        end
    end

    // Clears first so a same-cycle issue to the same register keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (head_grant)
            busy_d[head_wn] = 1'b0;
        if (bypass)
            busy_d[MDwn] = 1'b0;
        if (MDissue && (MDissue_wn != 5'd0))
            busy_d[MDissue_wn] = 1'b1;
    end

    assign IDstall = ((IDrs != 5'd0) && busy_q[IDrs])
                  || ((IDrt != 5'd0) && busy_q[IDrt])
                  || (IDwreg && (IDwn != 5'd0) && busy_q[IDwn])
                  || (state_q == S_DRAIN);

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (head_grant)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (MDvalid && !MDready)
                ovf_q <= 1'b1;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wn_q[wr_ptr_q]   <= MDwn;
            fifo_data_q[wr_ptr_q] <= MDdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            deny_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    deny_q <= '0;
                    if (push)
                        state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (count_d == '0) begin
                        state_q <= S_IDLE;
                        deny_q  <= '0;
                    end else if (head_grant) begin
                        deny_q  <= '0;
                    end else if (deny_q == DW'(STARVE_LIMIT - 1)) begin
                        state_q <= S_DRAIN;
                        deny_q  <= '0;
                    end else begin
                        deny_q  <= deny_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    deny_q <= '0;
                    if (count_d == '0)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    deny_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_wb_arbiter.sv
// tb/tb_pipe_wb_arbiter.sv - self-checking bench for pipe_wb_arbiter against a queue-based reference model
module tb_pipe_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk, clr;
    logic WBwreg, MDissue, MDvalid, IDwreg;
    logic [4:0] WBwn, MDissue_wn, MDwn, IDrs, IDrt, IDwn;
    logic [31:0] WBdata, MDdata;
    logic MDready, IDstall, RFwe, MDoverflow;
    logic [4:0] RFwn;
    logic [31:0] RFdata;
    logic [40:0] dut_vec;

    int checks = 0;
    int errors = 0;

    bit [36:0] mq[$];
    bit [31:0] m_busy;
    bit m_ovf, m_drain;
    int m_deny;

    pipe_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .clr(clr),
        .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
        .MDissue(MDissue), .MDissue_wn(MDissue_wn),
        .MDvalid(MDvalid), .MDwn(MDwn), .MDdata(MDdata), .MDready(MDready),
        .IDrs(IDrs), .IDrt(IDrt), .IDwn(IDwn), .IDwreg(IDwreg), .IDstall(IDstall),
        .RFwe(RFwe), .RFwn(RFwn), .RFdata(RFdata), .MDoverflow(MDoverflow)
    );

    assign dut_vec = {RFwe, RFwn, RFdata, MDready, IDstall, MDoverflow};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [40:0] model_out();
        logic wbw, hg, rdy, byp, we, st;
        logic [4:0] wn;
        logic [31:0] d;
        wbw = WBwreg && (WBwn != 0);
        hg  = !wbw && (mq.size() > 0);
        rdy = (mq.size() < DEPTH) || hg;
        byp = 1'b0;
`ifdef PIPE_WBARB_BYPASS_EN
        byp = MDvalid && (mq.size() == 0) && !wbw && (MDwn != 0);
`endif
        we = 1'b0; wn = 5'd0; d = 32'd0;
        if (wbw) begin
            we = 1'b1; wn = WBwn; d = WBdata;
        end else if (hg) begin
            we = 1'b1; wn = mq[0][36:32]; d = mq[0][31:0];
        end else if (byp) begin
            we = 1'b1; wn = MDwn; d = MDdata;
        end
        st = m_drain || ((IDrs != 0) && m_busy[IDrs]) || ((IDrt != 0) && m_busy[IDrt])
           || (IDwreg && (IDwn != 0) && m_busy[IDwn]);
        return {we, wn, d, rdy, st, m_ovf};
    endfunction

    always @(posedge clk) begin : model
        bit wbw, hg, rdy, byp;
        int pre;
        if (clr) begin
            mq.delete();
            m_busy = 0; m_ovf = 0; m_drain = 0; m_deny = 0;
        end else begin
            pre = mq.size();
            wbw = WBwreg && (WBwn != 0);
            hg  = !wbw && (pre > 0);
            rdy = (pre < DEPTH) || hg;
            byp = 1'b0;
`ifdef PIPE_WBARB_BYPASS_EN
            byp = MDvalid && (pre == 0) && !wbw && (MDwn != 0);
`endif
            if (hg) begin
                m_busy[mq[0][36:32]] = 1'b0;
                void'(mq.pop_front());
            end
            if (byp) m_busy[MDwn] = 1'b0;
            if (MDvalid && !rdy) m_ovf = 1'b1;
            else if (MDvalid && (MDwn != 0) && !byp) mq.push_back({MDwn, MDdata});
            if (MDissue && (MDissue_wn != 0)) m_busy[MDissue_wn] = 1'b1;
            // Starvation: consecutive denied cycles of a waiting head, not counted while draining.
            if (m_drain) m_deny = 0;
            else if (pre > 0 && !hg) m_deny = m_deny + 1;
            else m_deny = 0;
            if (m_deny == STARVE_LIMIT) begin
                m_drain = 1'b1;
                m_deny = 0;
            end
            if (mq.size() == 0) begin
                m_drain = 1'b0;
                m_deny = 0;
            end
        end
    end

    task automatic drive_idle();
        WBwreg = 0; WBwn = 0; WBdata = 0;
        MDissue = 0; MDissue_wn = 0;
        MDvalid = 0; MDwn = 0; MDdata = 0;
        IDrs = 0; IDrt = 0; IDwn = 0; IDwreg = 0;
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1;
        drive_idle();
        wait_edge();
        wait_edge();
        clr = 0;
        IDrs = 5'd5; IDrt = 5'd17; IDwn = 5'd31; IDwreg = 1;
        @(negedge clk);
        checks++;
        if (dut_vec !== {1'b1 ^ 1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec, {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", dut_vec, model_out());
        end
        wait_edge();
        drive_idle();
    endtask

    task automatic test_md_basic();
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            if (i == 0) begin MDissue = 1; MDissue_wn = 5'd5; end
            if (i >= 1) IDrs = 5'd5;
            if (i == 1) begin MDvalid = 1; MDwn = 5'd5; MDdata = 32'h1234; end
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL md_basic cycle %0d: got %h expected %h", i, dut_vec, model_out());
            end
            if (i == 1) begin
                checks++;
                if (IDstall !== 1'b1) begin
                    errors++;
                    $display("FAIL md_basic_stall: IDstall got %b expected 1", IDstall);
                end
            end
`ifndef PIPE_WBARB_BYPASS_EN
            if (i == 2) begin
                checks++;
                if ({RFwe, RFwn, RFdata} !== {1'b1, 5'd5, 32'h1234}) begin
                    errors++;
                    $display("FAIL md_basic_write: got %b/%0d/%h expected 1/5/1234", RFwe, RFwn, RFdata);
                end
            end
`endif
            if (i == 3) begin
                checks++;
                if (IDstall !== 1'b0) begin
                    errors++;
                    $display("FAIL md_basic_unstall: IDstall got %b expected 0", IDstall);
                end
            end
            wait_edge();
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 9; i++) begin
            drive_idle();
            if (i <= 5) begin WBwreg = 1; WBwn = 5'd3; WBdata = $urandom; end
            if (i == 0) begin MDvalid = 1; MDwn = 5'd7; MDdata = 32'hCAFE_0007; end
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL starve cycle %0d: got %h expected %h", i, dut_vec, model_out());
            end
            if (i == 5) begin
                checks++;
                if (IDstall !== 1'b1) begin
                    errors++;
                    $display("FAIL starve_drain_stall: IDstall got %b expected 1", IDstall);
                end
            end
            if (i == 6) begin
                checks++;
                if ({RFwe, RFwn, RFdata} !== {1'b1, 5'd7, 32'hCAFE_0007}) begin
                    errors++;
                    $display("FAIL starve_write: got %b/%0d/%h expected 1/7/cafe0007", RFwe, RFwn, RFdata);
                end
            end
            if (i == 7) begin
                checks++;
                if ({RFwe, IDstall} !== 2'b00) begin
                    errors++;
                    $display("FAIL starve_idle: RFwe/IDstall got %b%b expected 00", RFwe, IDstall);
                end
            end
            wait_edge();
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            drive_idle();
            if (i <= 3) begin WBwreg = 1; WBwn = 5'd3; WBdata = $urandom; end
            if (i <= 2) begin MDvalid = 1; MDwn = 5'(i + 1); MDdata = $urandom; end
            clr = (i == 8);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL overflow cycle %0d: got %h expected %h", i, dut_vec, model_out());
            end
            if (i == 2) begin
                checks++;
                if (MDready !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_ready: MDready got %b expected 0", MDready);
                end
            end
            if (i == 3 || i == 7 || i == 9) begin
                checks++;
                if (MDoverflow !== (i != 9)) begin
                    errors++;
                    $display("FAIL overflow_sticky cycle %0d: got %b expected %b", i, MDoverflow, i != 9);
                end
            end
            wait_edge();
        end
        clr = 0;
    endtask

    task automatic test_r0();
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            if (i == 0) begin MDvalid = 1; MDwn = 5'd0; MDdata = 32'hDEAD; MDissue = 1; MDissue_wn = 5'd0; end
            if (i == 2) begin WBwreg = 1; WBwn = 5'd0; WBdata = 32'hBEEF; end
            IDwreg = 1;
            @(negedge clk);
            checks++;
            if ({RFwe, RFwn, RFdata, IDstall} !== 39'd0) begin
                errors++;
                $display("FAIL r0_dropped cycle %0d: RFwe/RFwn/RFdata/IDstall got %b/%0d/%h/%b expected all 0",
                         i, RFwe, RFwn, RFdata, IDstall);
            end
            wait_edge();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            MDvalid = 1; MDwn = 5'(8 + i); MDdata = $urandom;
            MDissue = (i < 7); MDissue_wn = 5'(9 + i);
            IDrt = 5'(8 + i);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, dut_vec, model_out());
            end
            wait_edge();
        end
        drive_idle();
    endtask

`ifdef PIPE_WBARB_BYPASS_EN
    task automatic test_bypass();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            if (i == 0) begin MDvalid = 1; MDwn = 5'd9; MDdata = 32'hABCD; end
            @(negedge clk);
            checks++;
            if ({RFwe, RFwn, RFdata} !== ((i == 0) ? {1'b1, 5'd9, 32'hABCD} : 38'd0)) begin
                errors++;
                $display("FAIL bypass cycle %0d: got %b/%0d/%h", i, RFwe, RFwn, RFdata);
            end
            wait_edge();
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clr        = ($urandom_range(0, 99) == 0);
            WBwreg     = ($urandom_range(0, 99) < 55);
            WBwn       = 5'($urandom_range(0, 7));
            WBdata     = $urandom;
            MDissue    = ($urandom_range(0, 99) < 25);
            MDissue_wn = 5'($urandom_range(0, 7));
            MDvalid    = ($urandom_range(0, 99) < 35);
            MDwn       = 5'($urandom_range(0, 7));
            MDdata     = $urandom;
            IDrs       = 5'($urandom_range(0, 7));
            IDrt       = 5'($urandom_range(0, 7));
            IDwn       = 5'($urandom_range(0, 7));
            IDwreg     = $urandom_range(0, 1);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, model_out());
            end
            wait_edge();
        end
        clr = 0;
        drive_idle();
    endtask

    initial begin
        clr = 1;
        drive_idle();
        test_reset();
        test_md_basic();
        test_starve();
        test_overflow();
        test_r0();
        test_back_to_back();
`ifdef PIPE_WBARB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_wb_arbiter.md
# pipe_wb_arbiter

Arbitrates the single register-file write port between the in-order WB stage and a multi-cycle mul/div unit (MD) that retires results out of band. MD results are buffered in a small FIFO and written when WB leaves the port idle. A 32-bit scoreboard tracks pending MD destinations and produces the ID-stage stall that keeps RAW and WAW hazards from reaching the register file. Sits between the WB stage, the MD unit and `pipe_regfile`'s write port; the stall is ORed into the ID control's stall logic (IFwip/IDwir).

## Interface

Parameters:
- DEPTH, 2, number of MD result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles an MD head may be denied before a forced drain

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset: synchronous, active-high
- WBwreg  in  1  WB stage write enable
- WBwn  in  5  WB destination register
- WBdata  in  32  WB write data
- MDissue  in  1  ID issues an MD op this cycle (already stall-qualified)
- MDissue_wn  in  5  destination register of the issued MD op
- MDvalid  in  1  one-cycle MD result pulse
- MDwn  in  5  MD result destination
- MDdata  in  32  MD result data
- MDready  out  1  FIFO not full
- IDrs, IDrt, IDwn  in  5 each  source and destination registers of the instruction in ID
- IDwreg  in  1  instruction in ID writes a register
- IDstall  out  1  stall ID/IF this cycle
- RFwe  out  1  register-file write enable
- RFwn  out  5  register-file write register
- RFdata  out  32  register-file write data
- MDoverflow  out  1  sticky: MDvalid arrived while the FIFO was full

## Operation

- Port grant, combinational each cycle. WB wins when WBwreg=1 and WBwn≠0. Otherwise the FIFO head is written if the FIFO is non-empty. Otherwise RFwe=0.
- When RFwe=0, RFwn and RFdata are 0.
- Writes to r0 are dropped:
  - MD results with MDwn=0 are not enqueued.
  - MDissue with MDissue_wn=0 sets no busy bit.
- Scoreboard busy[31:0]:
  - MDissue sets busy[MDissue_wn].
  - A FIFO-head write clears busy[head wn].
  - If both hit the same register in the same cycle, set wins.
- IDstall=1 when any of the following holds:
  - busy[IDrs] or busy[IDrt] is set (index 0 is ignored).
  - IDwreg=1 and busy[IDwn] is set.
  - The FSM is in DRAIN.
- FIFO:
  - Push on MDvalid & MDready & MDwn≠0.
  - Pop when the head is granted.
  - Push and pop in the same cycle are both allowed when the FIFO is full: the pop frees the slot, so MDready = !full | head_granted.
  - Pointers wrap modulo DEPTH.
  - MDvalid while not ready drops the result and sets MDoverflow. MDoverflow is cleared only by clr.
- FSM:
  - IDLE: FIFO empty. Goes to WAIT on a push.
  - WAIT: FIFO non-empty. The deny counter increments on each cycle the head is not granted and resets to 0 on each grant. Goes to IDLE when the FIFO becomes empty. Goes to DRAIN when the counter reaches STARVE_LIMIT.
  - DRAIN: holds IDstall=1 so that bubbles reach WB and the FIFO drains. Goes to IDLE when the FIFO is empty. The counter is 0 on entry to IDLE.

## Timing

- Reset (clr=1 at a clock edge): FIFO empty, busy=0, FSM=IDLE, counter=0, MDoverflow=0.
  - Resulting outputs: MDready=1, IDstall=0 (with IDrs/IDrt/IDwn irrelevant), RFwe=0, RFwn=0, RFdata=0.
  - clr mid-operation discards all buffered results and pending busy bits.
- Latency without bypass: an MD result pushed at edge N is written to the register file no earlier than the cycle after N (the head is granted combinationally in cycle N+1).
- A busy bit set at edge N causes IDstall from cycle N+1. The bit is cleared at the edge that ends the head's write cycle.
- RFwe, RFwn and RFdata are combinational from WB inputs and FIFO state; pipe_regfile captures them on its own edge.

## Configuration

- PIPE_WBARB_BYPASS_EN defined: when MDvalid=1, the FIFO is empty and WB is not writing, the MD result is driven onto RFwe/RFwn/RFdata in the same cycle.
  - The result is not enqueued.
  - Its busy bit is cleared at that edge, with set-wins still applying.
- PIPE_WBARB_BYPASS_EN undefined: every MD result passes through the FIFO, with a minimum of 1 cycle of latency.

## Test plan

- Reset, then idle: RFwe=0, MDready=1, IDstall=0, busy=0, MDoverflow=0.
- MDissue wn=5; IDrs=5 on the next cycle -> IDstall=1. MDvalid wn=5, data=0x1234 with WB idle -> next cycle RFwe=1, RFwn=5, RFdata=0x1234; the following cycle IDstall=0.
- WB writes r3 continuously while MD result r7 is pending, STARVE_LIMIT=4 -> head denied 4 cycles, FSM enters DRAIN, IDstall=1. Once WBwreg=0, r7 is written and the FSM returns to IDLE.
- Fill the FIFO (DEPTH=2) under WB contention, then a third MDvalid -> MDready=0, result dropped, MDoverflow=1 and stays 1 until clr.
- MDvalid wn=0 -> no push, RFwe stays 0. A WB write to r0 -> RFwe=0.
- With PIPE_WBARB_BYPASS_EN, MDvalid wn=9, data=0xABCD on an idle port -> RFwe=1, RFwn=9, RFdata=0xABCD in the same cycle; FIFO stays empty.
